// File: rtl/nms_stream_tx_if.sv
// Stream bundle between the score pipeline, the transmitter and the NMS
// line-buffer window: valid/ready score input plus the ce-strobed output.
interface nms_stream_tx_if #(
  parameter int SCORE_W = 13
);
  logic               s_valid;
  logic               s_ready;
  logic               s_sof;
  logic [SCORE_W-1:0] s_score;
  logic               ce;
  logic [9:0]         x_coord_out;
  logic [9:0]         y_coord_out;
  logic [SCORE_W-1:0] data_out;

  // Producer side: drives scores, observes ready and the emitted stream.
  modport master (
    output s_valid, s_sof, s_score,
    input  s_ready, ce, x_coord_out, y_coord_out, data_out
  );

  // Transmitter side.
  modport slave (
    input  s_valid, s_sof, s_score,
    output s_ready, ce, x_coord_out, y_coord_out, data_out
  );
endinterface

// File: rtl/nms_stream_tx.sv
// Raster-stream transmitter feeding the NMS window. Tags accepted scores
// with raster coordinates, emits them as a registered ce strobe, and at
// frame end appends zero-score flush pixels so the window drains.
// Optional feature macro: NMS_STREAM_TX_ERR_CNT_EN adds sof_err_cnt and
// drop_cnt error counters.
module nms_stream_tx #(
  parameter int COL_NUM  = 640,
  parameter int ROW_NUM  = 480,
  parameter int NMS_SIZE = 3,
  parameter int SCORE_W  = 13
) (
  input  logic         clk,
  input  logic         rst,
  nms_stream_tx_if.slave bus,
  output logic         frame_done,
  output logic         sof_err
`ifdef NMS_STREAM_TX_ERR_CNT_EN
  ,
  output logic [7:0]   sof_err_cnt,
  output logic [15:0]  drop_cnt
`endif
);

  localparam int FLUSH_LEN = (NMS_SIZE / 2) * COL_NUM + NMS_SIZE / 2;
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  localparam logic [9:0]    X_LAST  = 10'(COL_NUM - 1);
  localparam logic [9:0]    Y_LAST  = 10'(ROW_NUM - 1);
  localparam logic [9:0]    Y_FLUSH = 10'(ROW_NUM);
  localparam logic [FW-1:0] F_LAST  = FW'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic [FW-1:0]      flush_q, flush_d;
  logic               ce_q, ce_d;
  logic [9:0]         xo_q, xo_d, yo_q, yo_d;
  logic [SCORE_W-1:0] data_q, data_d;
  logic               last_flush, last_q;
  logic               drop_ev, sof_ev;
  logic               take, xfer;
  logic [9:0]         ex, ey;

  // Ready is held low during reset and while flush pixels are emitted.
  assign bus.s_ready = !rst && (state_q != S_FLUSH);
  assign xfer        = bus.s_valid && bus.s_ready;

  assign bus.ce          = ce_q;
  assign bus.x_coord_out = xo_q;
  assign bus.y_coord_out = yo_q;
  assign bus.data_out    = data_q;

  // Next-state, raster counters and next output beat.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    flush_d    = flush_q;
    ce_d       = 1'b0;
    xo_d       = xo_q;
    yo_d       = yo_q;
    data_d     = data_q;
    last_flush = 1'b0;
    drop_ev    = 1'b0;
    sof_ev     = 1'b0;
    take       = 1'b0;
    ex         = x_q;
    ey         = y_q;

    case (state_q)
      S_IDLE: begin
        // Only an SOF beat opens a frame; anything else is dropped.
        if (xfer) begin
          if (bus.s_sof) begin
            take = 1'b1;
            ex   = '0;
            ey   = '0;
          end else begin
            drop_ev = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (xfer) begin
          take = 1'b1;
          // SOF away from the origin: resync the raster to this beat.
          if (bus.s_sof && (x_q != '0 || y_q != '0)) begin
            sof_ev = 1'b1;
            ex     = '0;
            ey     = '0;
          end
        end
      end
      S_FLUSH: begin
        ce_d   = 1'b1;
        xo_d   = x_q;
        yo_d   = y_q;
        data_d = '0;
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + 10'd1;
        end else begin
          x_d = x_q + 10'd1;
        end
        if (flush_q == F_LAST) begin
          state_d    = S_IDLE;
          x_d        = '0;
          y_d        = '0;
          flush_d    = '0;
          last_flush = 1'b1;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accepted beat: emit at (ex,ey), then advance or start the flush.
    if (take) begin
      ce_d   = 1'b1;
      xo_d   = ex;
      yo_d   = ey;
      data_d = bus.s_score;
      if (ex == X_LAST && ey == Y_LAST) begin
        state_d = S_FLUSH;
        x_d     = '0;
        y_d     = Y_FLUSH;
        flush_d = '0;
      end else begin
        state_d = S_ACTIVE;
        if (ex == X_LAST) begin
          x_d = '0;
          y_d = ey + 10'd1;
        end else begin
          x_d = ex + 10'd1;
          y_d = ey;
        end
      end
    end
  end

  // State, counters, registered output beat and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      flush_q    <= '0;
      ce_q       <= 1'b0;
      xo_q       <= '0;
      yo_q       <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      flush_q    <= flush_d;
      ce_q       <= ce_d;
      xo_q       <= xo_d;
      yo_q       <= yo_d;
      data_q     <= data_d;
      // frame_done trails the last flush beat by one cycle.
      last_q     <= last_flush;
      frame_done <= last_q;
      sof_err    <= sof_err | sof_ev;
    end
  end

`ifdef NMS_STREAM_TX_ERR_CNT_EN
  // Saturating counters for mid-frame SOFs and beats dropped in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sof_err_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (sof_ev && sof_err_cnt != 8'hFF)
        sof_err_cnt <= sof_err_cnt + 8'd1;
      if (drop_ev && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nms_stream_tx.sv
// Directed bench for nms_stream_tx at COL_NUM=8, ROW_NUM=4, NMS_SIZE=3
// (flush length 9). Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point.
module tb_nms_stream_tx;
  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int SW   = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_done, sof_err;
`ifdef NMS_STREAM_TX_ERR_CNT_EN
  logic [7:0]  sof_err_cnt;
  logic [15:0] drop_cnt;
`endif

  int errs   = 0;
  int checks = 0;

  nms_stream_tx_if #(.SCORE_W(SW)) bus();

  nms_stream_tx #(
    .COL_NUM(COLS), .ROW_NUM(ROWS), .NMS_SIZE(3), .SCORE_W(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .frame_done(frame_done),
    .sof_err(sof_err)
`ifdef NMS_STREAM_TX_ERR_CNT_EN
    ,
    .sof_err_cnt(sof_err_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sof, input int score);
    bus.s_valid = v;
    bus.s_sof   = sof;
    bus.s_score = SW'(score);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 0);
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out, frame_done, sof_err, bus.s_ready} !== '0)
      begin errs++; $display("FAIL reset_values got ce=%b x=%0d y=%0d d=%0d fd=%b se=%b rdy=%b want all 0",
        bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out, frame_done, sof_err, bus.s_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin errs++; $display("FAIL reset_idle_ready got %b want 1", bus.s_ready); end
  endtask

  task automatic test_frame();
    int rl = 0, fd = 0;
    step();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, i == 0, 100 + i);
      step();
      checks++;
      if ({bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out} !== {1'b1, 10'(i % COLS), 10'(i / COLS), SW'(100 + i)})
        begin errs++; $display("FAIL frame_beat%0d got ce=%b x=%0d y=%0d d=%0d want x=%0d y=%0d d=%0d",
          i, bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out, i % COLS, i / COLS, 100 + i); end
    end
    drive(1'b0, 1'b0, 0);
    for (int k = 0; k < 9; k++) begin
      if (bus.s_ready === 1'b0) rl++;
      step();
      if (frame_done === 1'b1) fd++;
      checks++;
      if ({bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out} !== {1'b1, 10'(k % COLS), 10'(ROWS + k / COLS), SW'(0)})
        begin errs++; $display("FAIL flush_beat%0d got ce=%b x=%0d y=%0d d=%0d want x=%0d y=%0d d=0",
          k, bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out, k % COLS, ROWS + k / COLS); end
    end
    checks++;
    if (rl != 9) begin errs++; $display("FAIL flush_ready_low got %0d cycles want 9", rl); end
    checks++;
    if (fd != 0 || frame_done !== 1'b0) begin errs++; $display("FAIL done_early got %0d pulses want 0", fd); end
    checks++;
    if (bus.s_ready !== 1'b1) begin errs++; $display("FAIL ready_after_flush got %b want 1", bus.s_ready); end
    step();
    checks++;
    if ({frame_done, bus.ce} !== 2'b10) begin errs++; $display("FAIL frame_done_pulse got fd=%b ce=%b want fd=1 ce=0", frame_done, bus.ce); end
    step();
    checks++;
    if (frame_done !== 1'b0) begin errs++; $display("FAIL frame_done_width got %b want 0", frame_done); end
  endtask

  task automatic test_drop();
    int rl = 0, ce_n = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 50 + i);
      if (bus.s_ready !== 1'b1) rl++;
      step();
      if (bus.ce !== 1'b0) ce_n++;
    end
    checks++;
    if (ce_n != 0) begin errs++; $display("FAIL drop_ce got %0d strobes want 0", ce_n); end
    checks++;
    if (rl != 0) begin errs++; $display("FAIL drop_ready got %0d low cycles want 0", rl); end
    drive(1'b1, 1'b1, 77);
    step();
    checks++;
    if ({bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out} !== {1'b1, 10'd0, 10'd0, SW'(77)})
      begin errs++; $display("FAIL drop_then_sof got ce=%b x=%0d y=%0d d=%0d want (0,0) d=77",
        bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out); end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (frame_done !== 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (n >= 40) begin errs++; $display("FAIL %s_done_timeout got no frame_done within 40 cycles want pulse", tag); end
    step();
  endtask

  // Continues the frame opened by test_drop with a 1/0 valid pattern.
  task automatic test_gaps();
    for (int j = 1; j < 32; j++) begin
      drive(1'b1, 1'b0, 200 + j);
      step();
      checks++;
      if ({bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out} !== {1'b1, 10'(j % COLS), 10'(j / COLS), SW'(200 + j)})
        begin errs++; $display("FAIL gap_beat%0d got ce=%b x=%0d y=%0d d=%0d want x=%0d y=%0d d=%0d",
          j, bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out, j % COLS, j / COLS, 200 + j); end
      drive(1'b0, 1'b0, 0);
      if (j < 31) begin
        step();
        checks++;
        if (bus.ce !== 1'b0) begin errs++; $display("FAIL gap_idle%0d got ce=%b want 0", j, bus.ce); end
      end
    end
    wait_done("gaps");
  endtask

  task automatic test_mid_sof();
    int rl = 0, fd = 0;
    checks++;
    if (sof_err !== 1'b0) begin errs++; $display("FAIL sof_err_pre got %b want 0", sof_err); end
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, (i == 0) || (i == 13), 300 + i);
      step();
      checks++;
      if (i < 13) begin
        if ({bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out} !== {1'b1, 10'(i % COLS), 10'(i / COLS), SW'(300 + i)})
          begin errs++; $display("FAIL mid_beat%0d got x=%0d y=%0d d=%0d want x=%0d y=%0d", i,
            bus.x_coord_out, bus.y_coord_out, bus.data_out, i % COLS, i / COLS); end
      end else begin
        if ({bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out, sof_err} !== {1'b1, 10'd0, 10'd0, SW'(313), 1'b1})
          begin errs++; $display("FAIL mid_resync got ce=%b x=%0d y=%0d d=%0d se=%b want (0,0) d=313 se=1",
            bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out, sof_err); end
      end
    end
    for (int j = 1; j < 32; j++) begin
      drive(1'b1, 1'b0, 400 + j);
      if (bus.s_ready !== 1'b1) rl++;
      step();
      if (frame_done === 1'b1) fd++;
      checks++;
      if ({bus.ce, bus.x_coord_out, bus.y_coord_out, bus.data_out} !== {1'b1, 10'(j % COLS), 10'(j / COLS), SW'(400 + j)})
        begin errs++; $display("FAIL post_resync%0d got x=%0d y=%0d d=%0d want x=%0d y=%0d", j,
          bus.x_coord_out, bus.y_coord_out, bus.data_out, j % COLS, j / COLS); end
    end
    drive(1'b0, 1'b0, 0);
    checks++;
    if (rl != 0 || fd != 0) begin errs++; $display("FAIL aborted_frame got ready_low=%0d done=%0d want 0 0", rl, fd); end
    wait_done("mid_sof");
    checks++;
    if (sof_err !== 1'b1) begin errs++; $display("FAIL sof_err_sticky got %b want 1", sof_err); end
  endtask

  task automatic test_reset_flush();
    int ce_n = 0, fd = 0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, i == 0, 500 + i);
      step();
    end
    drive(1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) step();
    checks++;
    if ({bus.ce, bus.x_coord_out, bus.y_coord_out} !== {1'b1, 10'd3, 10'd4})
      begin errs++; $display("FAIL pre_rst_flush got ce=%b x=%0d y=%0d want ce=1 (3,4)", bus.ce, bus.x_coord_out, bus.y_coord_out); end
    rst = 1'b1;
    step();
    checks++;
    if ({bus.ce, bus.s_ready} !== 2'b00) begin errs++; $display("FAIL rst_flush_ce got ce=%b rdy=%b want 0 0", bus.ce, bus.s_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.s_ready, sof_err} !== 2'b10) begin errs++; $display("FAIL rst_flush_idle got rdy=%b se=%b want 1 0", bus.s_ready, sof_err); end
    for (int k = 0; k < 15; k++) begin
      step();
      if (bus.ce === 1'b1) ce_n++;
      if (frame_done === 1'b1) fd++;
    end
    checks++;
    if (ce_n != 0 || fd != 0) begin errs++; $display("FAIL rst_flush_abandon got ce=%0d done=%0d want 0 0", ce_n, fd); end
  endtask

`ifdef NMS_STREAM_TX_ERR_CNT_EN
  task automatic test_err_cnt();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, i);
      step();
    end
    checks++;
    if ({drop_cnt, sof_err_cnt} !== {16'd3, 8'd0}) begin errs++; $display("FAIL drop_cnt got %0d/%0d want 3/0", drop_cnt, sof_err_cnt); end
    drive(1'b1, 1'b1, 1);
    step();
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 9) begin
        checks++;
        if (sof_err_cnt !== 8'd10) begin errs++; $display("FAIL sof_err_cnt10 got %0d want 10", sof_err_cnt); end
      end
    end
    drive(1'b0, 1'b0, 0);
    step();
    checks++;
    if ({sof_err_cnt, drop_cnt, sof_err} !== {8'd255, 16'd3, 1'b1})
      begin errs++; $display("FAIL sof_err_cnt_sat got %0d drop=%0d se=%b want 255 3 1", sof_err_cnt, drop_cnt, sof_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_drop();
    test_gaps();
    test_mid_sof();
    test_reset_flush();
`ifdef NMS_STREAM_TX_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/nms_stream_tx.md
Name: nms_stream_tx

Overview:
- Raster-stream transmitter that feeds the NMS stage.
- Accepts FAST corner scores from the score pipeline over a valid/ready handshake and re-emits them as the ce-strobed stream the NMS line-buffer window consumes: ce, x/y coordinates and a 13-bit score.
- Tags every pixel with raster coordinates.
- At frame end, appends zero-score flush pixels so the NMS window drains the final rows before the next frame.

Parameters:
- COL_NUM, 640, pixels per row (≤1023).
- ROW_NUM, 480, rows per frame (≤1023).
- NMS_SIZE, 3, NMS window size; odd, ≥3.
- SCORE_W, 13, score width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream score valid.
- s_ready  out  1  block can accept a score.
- s_sof  in  1  qualifies the current s_valid beat as the first pixel of a frame.
- s_score  in  SCORE_W  corner score; 0 = not a corner.
- ce  out  1  one-cycle strobe: output beat valid.
- x_coord_out  out  10  column of output beat.
- y_coord_out  out  10  row of output beat.
- data_out  out  SCORE_W  score of output beat.
- frame_done  out  1  one-cycle pulse on the cycle after the last flush beat.
- sof_err  out  1  sticky: s_sof arrived mid-frame; cleared only by rst.

Behaviour:
- One clock domain; all state is reset synchronously by rst=1. Fixed: clock and reset are named clk and rst, reset is synchronous and active-high.
- Reset values:
  - ce=0, data_out=0, x_coord_out=0, y_coord_out=0.
  - frame_done=0, sof_err=0, s_ready=0.
  - State = IDLE, counters at 0.
- Handshake:
  - A beat transfers when s_valid and s_ready are both high on a rising edge.
  - ce, coordinates and data are registered: output appears 1 cycle after transfer.
  - Downstream has no backpressure; ce is strictly a strobe.
- FLUSH_LEN = (NMS_SIZE/2)*COL_NUM + NMS_SIZE/2. At defaults this is 641.
- States:
  - IDLE: s_ready=1.
    - Beats with s_sof=0 are accepted and discarded; ce stays 0.
    - A beat with s_sof=1 is emitted at (0,0); go to ACTIVE with x=1, y=0.
  - ACTIVE: s_ready=1. Each transfer emits the beat at the current (x,y), then advances the counters.
    - x increments; when x=COL_NUM-1, x wraps to 0 and y increments.
    - The transfer at (COL_NUM-1, ROW_NUM-1) emits, then moves to FLUSH with x=0, y=ROW_NUM.
  - FLUSH: s_ready=0. Emits one beat every cycle (ce=1) with data_out=0, for FLUSH_LEN cycles.
    - Coordinates continue the raster: y starts at ROW_NUM, x wraps as in ACTIVE.
    - After the final flush beat, go to IDLE; frame_done=1 for exactly the next cycle.
- Mid-frame SOF:
  - Trigger: s_sof=1 on a transfer in ACTIVE at any position other than (0,0).
  - sof_err is set and the frame resyncs: that beat is emitted at (0,0) and counters become x=1, y=0.
  - frame_done is not pulsed for the aborted frame, and no flush is issued.
- s_sof=1 is never seen in FLUSH, because s_ready=0 there.
- Idle cycles (s_valid=0) in ACTIVE produce ce=0 and leave the counters unchanged.
- Reset mid-operation (any state): the next cycle has ce=0, IDLE state, and a partial frame or flush is abandoned.
- COL_NUM=1 edge case: x stays 0 and y increments on every beat.

Optional Feature:
- Macro NMS_STREAM_TX_ERR_CNT_EN.
- Defined:
  - Adds output sof_err_cnt[7:0]: counts mid-frame SOF events, saturating at 255, reset to 0 by rst.
  - Adds output drop_cnt[15:0]: counts beats discarded in IDLE, saturating at 65535.
- Undefined:
  - Neither port nor its counter logic exists.
  - The sticky sof_err behaviour is unchanged.

Test Plan:
- Use COL_NUM=8, ROW_NUM=4, NMS_SIZE=3 unless stated otherwise; FLUSH_LEN=9.
1. Reset, then one 32-beat frame with continuous s_valid, s_sof on beat 0 → 32 ce beats with coordinates (0,0)…(7,3) and scores equal to the inputs, each 1 cycle after its transfer. Then 9 zero beats at (0,4)…(7,4),(0,5). frame_done pulses once, on the cycle after (0,5). s_ready=0 for exactly 9 cycles.
2. Send 5 beats with s_sof=0 from IDLE → no ce, s_ready=1 throughout. A following s_sof beat is emitted at (0,0).
3. s_valid toggled 1/0 every cycle during a frame → ce toggles to match; coordinates are contiguous and unaffected by gaps.
4. s_sof asserted again at beat 13, i.e. at (5,1) → sof_err=1, that beat emitted at (0,0), no frame_done and no flush. The next full frame completes normally and sof_err stays 1.
5. rst asserted for 1 cycle during FLUSH at flush beat 4 → ce=0 the following cycle, s_ready=1 in IDLE, sof_err=0, no frame_done pulse.
6. With NMS_STREAM_TX_ERR_CNT_EN: 300 mid-frame SOFs → sof_err_cnt saturates at 255. 3 discarded IDLE beats → drop_cnt=3.
